// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic-light monitor: phase codes, joint lamp
// observations and the legal-cycle helpers.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        PH_UNSYNC = 3'd0,
        PH_G1     = 3'd1,
        PH_Y1     = 3'd2,
        PH_AR1    = 3'd3,
        PH_G2     = 3'd4,
        PH_Y2     = 3'd5,
        PH_AR2    = 3'd6,
        PH_ARX    = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OBS_G1R2,
        OBS_Y1R2,
        OBS_R1G2,
        OBS_R1Y2,
        OBS_RR,
        OBS_DARK,
        OBS_CONFLICT,
        OBS_FAULT
    } obs_t;

    // ARX and UNSYNC have no single successor; UNSYNC is returned as "none".
    function automatic phase_t phase_succ(phase_t p);
        case (p)
            PH_G1:   return PH_Y1;
            PH_Y1:   return PH_AR1;
            PH_AR1:  return PH_G2;
            PH_G2:   return PH_Y2;
            PH_Y2:   return PH_AR2;
            PH_AR2:  return PH_G1;
            default: return PH_UNSYNC;
        endcase
    endfunction

    function automatic obs_t phase_obs(phase_t p);
        case (p)
            PH_G1:                  return OBS_G1R2;
            PH_Y1:                  return OBS_Y1R2;
            PH_G2:                  return OBS_R1G2;
            PH_Y2:                  return OBS_R1Y2;
            PH_AR1, PH_AR2, PH_ARX: return OBS_RR;
            default:                return OBS_DARK;
        endcase
    endfunction

    // State entered when an observation is seen without a valid predecessor.
    function automatic phase_t obs_entry(obs_t o);
        case (o)
            OBS_G1R2: return PH_G1;
            OBS_Y1R2: return PH_Y1;
            OBS_R1G2: return PH_G2;
            OBS_R1Y2: return PH_Y2;
            OBS_RR:   return PH_ARX;
            default:  return PH_UNSYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, error-clear strobe and status outputs of the traffic-light monitor.
interface traffic_light_monitor_if #(
    parameter int DW = 8,
    parameter int CW = 8
);
    logic          GRN1, YLW1, RED1;
    logic          GRN2, YLW2, RED2;
    logic          err_clr;
    logic [2:0]    phase;
    logic          phase_valid;
    logic [DW-1:0] dwell;
    logic [DW-1:0] last_dwell;
    logic [CW-1:0] cycle_cnt;
    logic          err_lamp, err_conflict, err_seq, err_dwell;

    modport master (
        output GRN1, YLW1, RED1, GRN2, YLW2, RED2, err_clr,
        input  phase, phase_valid, dwell, last_dwell, cycle_cnt,
        input  err_lamp, err_conflict, err_seq, err_dwell
    );

    modport slave (
        input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, err_clr,
        output phase, phase_valid, dwell, last_dwell, cycle_cnt,
        output err_lamp, err_conflict, err_seq, err_dwell
    );
endinterface

// File: rtl/tl_lamp_decode.sv
// Combinational decode of the six registered lamps into one joint observation.
// Lamp order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}.
module tl_lamp_decode
    import traffic_light_pkg::*;
(
    input  logic [5:0] lamps,
    output obs_t       obs
);
    logic [2:0] road1, road2;
    logic       r1_ok, r2_ok, r1_red, r2_red;

    assign road1  = lamps[5:3];
    assign road2  = lamps[2:0];
    assign r1_ok  = (road1 == 3'b100) || (road1 == 3'b010) || (road1 == 3'b001);
    assign r2_ok  = (road2 == 3'b100) || (road2 == 3'b010) || (road2 == 3'b001);
    assign r1_red = (road1 == 3'b001);
    assign r2_red = (road2 == 3'b001);

    // All-dark is reported separately so UNSYNC can ignore a powered-down controller.
    always_comb begin
        obs = OBS_FAULT;
        if (lamps == 6'b0)
            obs = OBS_DARK;
        else if (!r1_ok || !r2_ok)
            obs = OBS_FAULT;
        else if (!r1_red && !r2_red)
            obs = OBS_CONFLICT;
        else if (r1_red && r2_red)
            obs = OBS_RR;
        else if (r2_red)
            obs = road1[2] ? OBS_G1R2 : OBS_Y1R2;
        else
            obs = road2[2] ? OBS_R1G2 : OBS_R1Y2;
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side monitor: registers the lamps, tracks the legal phase cycle,
// measures phase dwell and raises sticky error flags.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_YLW = 3,
    parameter int DW      = 8,
    parameter int CW      = 8
) (
    input  logic                    clk,
    input  logic                    CLR,
    traffic_light_monitor_if.slave  bus
);
    localparam logic [2:0] S_UNSYNC = PH_UNSYNC;
    localparam logic [2:0] S_G1     = PH_G1;
    localparam logic [2:0] S_Y1     = PH_Y1;
    localparam logic [2:0] S_Y2     = PH_Y2;
    localparam logic [2:0] S_AR2    = PH_AR2;
    localparam logic [2:0] S_ARX    = PH_ARX;

    localparam logic [DW-1:0] MIN_YLW_W = DW'(MIN_YLW);

    function automatic logic [DW-1:0] dwell_sat_inc(logic [DW-1:0] v);
        return (&v) ? v : v + DW'(1);
    endfunction

    logic [5:0]    lamps_p0;
    obs_t          obs;
    logic [2:0]    state_p1, nxt;
    logic          vld_p1;
    logic [DW-1:0] dwell_p1, last_dwell_p1;
    logic [CW-1:0] cycle_cnt_p1;
    logic          err_lamp_p1, err_conflict_p1, err_seq_p1, err_dwell_p1;
    logic          set_lamp, set_conflict, set_seq, set_dwell;
    logic          changed;
    phase_t        cur, succ;

    tl_lamp_decode u_decode (
        .lamps (lamps_p0),
        .obs   (obs)
    );

    assign cur  = phase_t'(state_p1);
    assign succ = phase_succ(cur);

    always_comb begin
        nxt          = state_p1;
        set_lamp     = 1'b0;
        set_conflict = 1'b0;
        set_seq      = 1'b0;
        if (state_p1 == S_UNSYNC) begin
            // Dark, faulty and conflicting lamps never synchronise the monitor.
            if (obs inside {OBS_G1R2, OBS_Y1R2, OBS_R1G2, OBS_R1Y2, OBS_RR})
                nxt = obs_entry(obs);
        end else begin
            case (obs)
                OBS_DARK, OBS_FAULT: begin
                    set_lamp = 1'b1;
                    nxt      = S_UNSYNC;
                end
                OBS_CONFLICT: begin
                    set_conflict = 1'b1;
                    nxt          = S_UNSYNC;
                end
                default: begin
                    if (obs == phase_obs(cur))
                        nxt = state_p1;
                    else if (state_p1 == S_ARX && (obs == OBS_G1R2 || obs == OBS_R1G2))
                        nxt = obs_entry(obs);
                    else if (obs == phase_obs(succ))
                        nxt = succ;
                    else begin
                        set_seq = 1'b1;
                        nxt     = obs_entry(obs);
                    end
                end
            endcase
        end
    end

    assign changed   = (nxt != state_p1);
    assign set_dwell = changed && (state_p1 == S_Y1 || state_p1 == S_Y2)
                       && (dwell_p1 < MIN_YLW_W);

    // Stage p0: lamp input register
    always_ff @(posedge clk) begin
        if (CLR)
            lamps_p0 <= 6'b0;
        else
            lamps_p0 <= {bus.GRN1, bus.YLW1, bus.RED1, bus.GRN2, bus.YLW2, bus.RED2};
    end

    // Stage p1: phase FSM, dwell/cycle counters and sticky flags
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_p1        <= S_UNSYNC;
            vld_p1          <= 1'b0;
            dwell_p1        <= '0;
            last_dwell_p1   <= '0;
            cycle_cnt_p1    <= '0;
            err_lamp_p1     <= 1'b0;
            err_conflict_p1 <= 1'b0;
            err_seq_p1      <= 1'b0;
            err_dwell_p1    <= 1'b0;
        end else begin
            state_p1 <= nxt;
            vld_p1   <= (nxt != S_UNSYNC);
            if (changed) begin
                dwell_p1      <= DW'(1);
                last_dwell_p1 <= dwell_p1;
            end else begin
                dwell_p1 <= dwell_sat_inc(dwell_p1);
            end
            if (state_p1 == S_AR2 && nxt == S_G1)
                cycle_cnt_p1 <= cycle_cnt_p1 + CW'(1);
            // A new detection overrides a simultaneous clear.
            err_lamp_p1     <= (err_lamp_p1     & ~bus.err_clr) | set_lamp;
            err_conflict_p1 <= (err_conflict_p1 & ~bus.err_clr) | set_conflict;
            err_seq_p1      <= (err_seq_p1      & ~bus.err_clr) | set_seq;
            err_dwell_p1    <= (err_dwell_p1    & ~bus.err_clr) | set_dwell;
        end
    end

    assign bus.phase        = state_p1;
    assign bus.phase_valid  = vld_p1;
    assign bus.dwell        = dwell_p1;
    assign bus.last_dwell   = last_dwell_p1;
    assign bus.cycle_cnt    = cycle_cnt_p1;
    assign bus.err_lamp     = err_lamp_p1;
    assign bus.err_conflict = err_conflict_p1;
    assign bus.err_seq      = err_seq_p1;
    assign bus.err_dwell    = err_dwell_p1;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus a random lamp walk,
// every cycle compared against a behavioural model (DW=8 and DW=4 instances).
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    localparam logic [5:0] L_G1R2 = 6'b100_001;
    localparam logic [5:0] L_Y1R2 = 6'b010_001;
    localparam logic [5:0] L_R1G2 = 6'b001_100;
    localparam logic [5:0] L_R1Y2 = 6'b001_010;
    localparam logic [5:0] L_RR   = 6'b001_001;
    localparam logic [5:0] L_DARK = 6'b000_000;
    localparam logic [5:0] L_CONF = 6'b100_100;
    localparam logic [5:0] L_FLT  = 6'b011_001;
    localparam int         MINY   = 3;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    traffic_light_monitor_if #(.DW(8), .CW(8)) bus ();
    traffic_light_monitor_if #(.DW(4), .CW(8)) bus4 ();

    assign bus4.GRN1    = bus.GRN1;
    assign bus4.YLW1    = bus.YLW1;
    assign bus4.RED1    = bus.RED1;
    assign bus4.GRN2    = bus.GRN2;
    assign bus4.YLW2    = bus.YLW2;
    assign bus4.RED2    = bus.RED2;
    assign bus4.err_clr = bus.err_clr;

    traffic_light_monitor #(.MIN_YLW(MINY), .DW(8), .CW(8)) u_dut (
        .clk (clk), .CLR (clr), .bus (bus)
    );
    traffic_light_monitor #(.MIN_YLW(MINY), .DW(4), .CW(8)) u_dut4 (
        .clk (clk), .CLR (clr), .bus (bus4)
    );

    always #5 clk = ~clk;

    // Reference model state: dwell kept unbounded, saturated when compared.
    logic [5:0] m_lq;
    int m_st, m_dw, m_last, m_cyc;
    bit m_el, m_ec, m_es, m_ed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int road(input logic [2:0] r);
        case (r)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Legal successor in the G1,Y1,AR1,G2,Y2,AR2 ring; 0 means none.
    function automatic int succ_of(input int s);
        int tab [8] = '{0, 2, 3, 4, 5, 6, 1, 0};
        return tab[s];
    endfunction

    task automatic model_edge(input logic [5:0] l, input logic ec, input logic c);
        int r1, r2, tgt, nst, nx;
        bit rr, legal, dl, dc, ds, dd;
        if (c) begin
            m_lq = '0; m_st = 0; m_dw = 0; m_last = 0; m_cyc = 0;
            m_el = 0; m_ec = 0; m_es = 0; m_ed = 0;
            return;
        end
        r1    = road(m_lq[5:3]);
        r2    = road(m_lq[2:0]);
        rr    = (r1 == 3) && (r2 == 3);
        legal = (r1 != 0) && (r2 != 0) && (r1 == 3 || r2 == 3);
        if (rr)           tgt = 7;
        else if (r2 == 3) tgt = (r1 == 1) ? 1 : 2;
        else              tgt = (r2 == 1) ? 4 : 5;
        nst = m_st; dl = 0; dc = 0; ds = 0; dd = 0;
        if (m_st == 0) begin
            if (legal) nst = tgt;
        end else if (r1 == 0 || r2 == 0) begin
            dl = 1; nst = 0;
        end else if (!legal) begin
            dc = 1; nst = 0;
        end else begin
            nx = succ_of(m_st);
            if ((rr && (m_st == 3 || m_st == 6 || m_st == 7)) || (!rr && tgt == m_st))
                nst = m_st;
            else if (rr && (nx == 3 || nx == 6))
                nst = nx;
            else if (!rr && (tgt == nx || (m_st == 7 && (tgt == 1 || tgt == 4))))
                nst = tgt;
            else begin
                ds = 1; nst = tgt;
            end
        end
        if (nst != m_st) begin
            if ((m_st == 2 || m_st == 5) && m_dw < MINY) dd = 1;
            if (m_st == 6 && nst == 1) m_cyc = (m_cyc + 1) % 256;
            m_last = m_dw;
            m_dw   = 1;
        end else begin
            m_dw = m_dw + 1;
        end
        m_st = nst;
        m_el = (m_el && !ec) || dl;
        m_ec = (m_ec && !ec) || dc;
        m_es = (m_es && !ec) || ds;
        m_ed = (m_ed && !ec) || dd;
        m_lq = l;
    endtask

    task automatic compare_all();
        check_eq("phase",        bus.phase,        m_st);
        check_eq("phase_valid",  bus.phase_valid,  (m_st != 0));
        check_eq("dwell",        bus.dwell,        sat(m_dw, 255));
        check_eq("last_dwell",   bus.last_dwell,   sat(m_last, 255));
        check_eq("cycle_cnt",    bus.cycle_cnt,    m_cyc);
        check_eq("err_lamp",     bus.err_lamp,     m_el);
        check_eq("err_conflict", bus.err_conflict, m_ec);
        check_eq("err_seq",      bus.err_seq,      m_es);
        check_eq("err_dwell",    bus.err_dwell,    m_ed);
        check_eq("dw4_phase",    bus4.phase,       m_st);
        check_eq("dw4_dwell",    bus4.dwell,       sat(m_dw, 15));
        check_eq("dw4_last",     bus4.last_dwell,  sat(m_last, 15));
    endtask

    task automatic step(input logic [5:0] l, input logic ec, input logic c);
        {bus.GRN1, bus.YLW1, bus.RED1, bus.GRN2, bus.YLW2, bus.RED2} = l;
        bus.err_clr = ec;
        clr         = c;
        @(posedge clk);
        model_edge(l, ec, c);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] seq [6];
        logic [5:0] l;
        int pi, hl, r;
        seq = '{L_G1R2, L_Y1R2, L_RR, L_R1G2, L_R1Y2, L_RR};
        {bus.GRN1, bus.YLW1, bus.RED1, bus.GRN2, bus.YLW2, bus.RED2} = L_DARK;
        bus.err_clr = 1'b0;

        // Reset state
        step(L_DARK, 1'b0, 1'b1);
        check_eq("rst_phase", bus.phase, 0);
        check_eq("rst_valid", bus.phase_valid, 0);
        check_eq("rst_dwell", bus.dwell, 0);
        check_eq("rst_cycle", bus.cycle_cnt, 0);

        // Legal sequence
        hold(L_G1R2, 5); hold(L_Y1R2, 3); hold(L_RR, 2);
        hold(L_R1G2, 5); hold(L_R1Y2, 3); hold(L_RR, 2);
        hold(L_G1R2, 2);
        check_eq("legal_phase", bus.phase, 1);
        check_eq("legal_last", bus.last_dwell, 2);
        check_eq("legal_cycle", bus.cycle_cnt, 1);
        check_eq("legal_errs", {bus.err_lamp, bus.err_conflict, bus.err_seq, bus.err_dwell}, 0);

        // Short yellow
        step(L_DARK, 1'b0, 1'b1);
        hold(L_G1R2, 4); hold(L_Y1R2, 2); hold(L_RR, 2);
        check_eq("short_ylw_err", bus.err_dwell, 1);
        check_eq("short_ylw_phase", bus.phase, 3);
        check_eq("short_ylw_other", {bus.err_lamp, bus.err_conflict, bus.err_seq}, 0);

        // Conflict then all-red resync
        step(L_DARK, 1'b0, 1'b1);
        hold(L_G1R2, 2); hold(L_CONF, 1); hold(L_RR, 1);
        check_eq("conf_err", bus.err_conflict, 1);
        check_eq("conf_phase", bus.phase, 0);
        check_eq("conf_valid", bus.phase_valid, 0);
        hold(L_RR, 1);
        check_eq("conf_arx", bus.phase, 7);

        // Sequence error, then clear coinciding with a lamp fault
        step(L_DARK, 1'b0, 1'b1);
        hold(L_G1R2, 2); hold(L_R1G2, 2);
        check_eq("seq_err", bus.err_seq, 1);
        check_eq("seq_phase", bus.phase, 4);
        hold(L_FLT, 1);
        step(L_FLT, 1'b1, 1'b0);
        check_eq("clr_seq", bus.err_seq, 0);
        check_eq("clr_lamp", bus.err_lamp, 1);

        // Dwell saturation
        step(L_DARK, 1'b0, 1'b1);
        hold(L_G1R2, 20);
        check_eq("sat_dw4", bus4.dwell, 15);
        check_eq("sat_dw8", bus.dwell, 19);

        // Cycle counter wrap
        step(L_DARK, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            hold(L_G1R2, 2); hold(L_Y1R2, 3); hold(L_RR, 1);
            hold(L_R1G2, 2); hold(L_R1Y2, 3); hold(L_RR, 1);
        end
        check_eq("wrap_pre", bus.cycle_cnt, 255);
        hold(L_G1R2, 2);
        check_eq("wrap_cycle", bus.cycle_cnt, 0);

        // CLR mid-phase in Y2
        hold(L_Y1R2, 3); hold(L_RR, 1); hold(L_R1G2, 2); hold(L_R1Y2, 3);
        check_eq("mid_phase", bus.phase, 5);
        check_eq("mid_dwell", bus.dwell, 2);
        step(L_DARK, 1'b0, 1'b1);
        check_eq("mid_clr_phase", bus.phase, 0);
        check_eq("mid_clr_dwell", bus.dwell, 0);
        check_eq("mid_clr_last", bus.last_dwell, 0);
        hold(L_DARK, 3);
        check_eq("dark_phase", bus.phase, 0);
        check_eq("dark_errs", {bus.err_lamp, bus.err_conflict, bus.err_seq, bus.err_dwell}, 0);

        // Random walk around the legal cycle with glitches, clears and resets
        pi = 0; hl = 0;
        for (int i = 0; i < 800; i++) begin
            if (hl == 0) begin
                pi = (pi + 1) % 6;
                hl = $urandom_range(1, 5);
            end
            hl--;
            r = $urandom_range(0, 19);
            if (r == 0)      l = 6'($urandom_range(0, 63));
            else if (r == 1) l = seq[$urandom_range(0, 5)];
            else if (r == 2) l = L_CONF;
            else             l = seq[pi];
            step(l, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the two-road traffic-light controller: it samples the six lamp outputs (GRN1/YLW1/RED1, GRN2/YLW2/RED2), decodes the joint signal phase, tracks the legal phase sequence with a state machine, and measures the dwell time of each phase. It flags lamp faults, green/yellow conflicts, illegal transitions and short yellows as sticky error bits. It sits beside the controller in the app test harness and in on-chip self-check builds.

## Interface
- `MIN_YLW`, default 3: minimum legal yellow dwell, in cycles.
- `DW`, default 8: width of the dwell counters.
- `CW`, default 8: width of the completed-cycle counter.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `CLR` input 1: reset, synchronous and active-high.
- `GRN1`, `YLW1`, `RED1` input 1 each: road-1 lamps from the controller.
- `GRN2`, `YLW2`, `RED2` input 1 each: road-2 lamps from the controller.
- `err_clr` input 1: one-cycle pulse that clears the sticky error bits.
- `phase` output 3: decoded FSM state code.
- `phase_valid` output 1: high when the monitor is synchronised.
- `dwell` output DW: cycles spent so far in the current phase.
- `last_dwell` output DW: dwell of the most recently completed phase.
- `cycle_cnt` output CW: number of completed full signal cycles.
- `err_lamp`, `err_conflict`, `err_seq`, `err_dwell` output 1 each: sticky error flags.

## Operation
- Per-road decode: a road is G, Y or R when exactly one of its lamps is lit. All-dark or more than one lamp lit is a lamp fault.
- Joint observations:
  - G1R2, Y1R2, R1G2, R1Y2: one road non-red, the other red.
  - RR: both roads red.
  - DARK: all six lamps off.
  - CONFLICT: both roads non-red.
- FSM states, with codes: UNSYNC=0, G1=1, Y1=2, AR1=3, G2=4, Y2=5, AR2=6, ARX=7.
- Legal cycle: G1→Y1→AR1→G2→Y2→AR2→G1. ARX is the all-red state reached from UNSYNC and accepts G1 or G2 next.
- Staying in the same observation keeps the current state.
- UNSYNC:
  - DARK and lamp faults are ignored.
  - The first legal observation enters the matching state; RR enters ARX.
  - `phase_valid` = 0 only in UNSYNC.
- When synchronised:
  - Lamp fault → set `err_lamp`, go to UNSYNC.
  - CONFLICT → set `err_conflict`, go to UNSYNC.
  - Legal observation that is not the successor of the current state → set `err_seq`, jump to the matching state (RR → ARX).
- Dwell:
  - `dwell` loads 1 on any state change and otherwise increments, saturating at 2^DW−1.
  - On a state change, `last_dwell` ← `dwell`.
  - Leaving Y1 or Y2 with `dwell` < MIN_YLW sets `err_dwell`.
- `cycle_cnt` increments on the AR2→G1 transition only and wraps modulo 2^CW.
- Error flags are sticky. `err_clr` clears them; an error detected in the same cycle as `err_clr` wins and stays set.
- `CLR` at any time, including mid-phase, forces every output to its reset value the next edge.

## Timing
- Reset values: `phase` = 0 (UNSYNC), `phase_valid` = 0, `dwell` = 0, `last_dwell` = 0, `cycle_cnt` = 0, all error flags = 0.
- Lamp inputs are registered once at edge k. The FSM, counters and error flags update at edge k+1. Every output is registered.
- Latency: a lamp change is visible on the outputs 2 cycles after it appears at the inputs.
- A one-cycle lamp glitch is not filtered; it is treated as a real observation.
- `err_clr` acts at the edge where it is sampled, with no input register.

## Structure
- Shared package `traffic_light_pkg` holds:
  - the state/phase enum and its codes;
  - the observation enum (G1R2, Y1R2, R1G2, R1Y2, RR, DARK, CONFLICT, FAULT);
  - a successor function for the legal cycle.
- Sub-module `tl_lamp_decode`: combinational; takes the six registered lamps and returns the observation. Per-road one-hot checks live here.
- Top level holds the input register, FSM, dwell/last_dwell counters, cycle counter and sticky flags.

## Test plan
- Legal sequence: after CLR, drive G1R2×5, Y1R2×3, RR×2, R1G2×5, R1Y2×3, RR×2, G1R2 → states 1,2,3,4,5,6,1; `last_dwell` values 5,3,2,5,3,2; `cycle_cnt` = 1; no errors.
- Short yellow: G1R2×4 then Y1R2×2 then RR → `err_dwell` = 1 two cycles after RR is applied; state AR1; other flags 0.
- Conflict: synchronised in G1, drive GRN1=1 and GRN2=1 for one cycle → `err_conflict` = 1, `phase` = 0, `phase_valid` = 0. Then RR → ARX (7).
- Sequence error and clear: in G1, drive R1G2 → `err_seq` = 1, `phase` = 4. Pulse `err_clr` in the same cycle that a lamp fault (RED1+YLW1) is detected → `err_seq` = 0, `err_lamp` = 1.
- Saturation/wrap: with DW=4, hold G1R2 for 20 cycles → `dwell` = 15. Run 256 full cycles with CW=8 → `cycle_cnt` = 0.
- CLR mid-operation: assert CLR during Y2 with `dwell` = 2 → next edge all outputs at reset values. DARK afterwards keeps UNSYNC with no errors.
